// File: rtl/screen_pkg.sv
// Shared screen geometry, coordinate/colour widths and plot-stage state encoding.
package screen_pkg;
  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;
  localparam int SCREEN_PIXELS = SCREEN_W * SCREEN_H;
  localparam int X_W           = 8;
  localparam int Y_W           = 7;
  localparam int COLOUR_W      = 3;
  localparam int CNT_W         = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } screen_state_t;
endpackage

// File: rtl/plot_align_pipe.sv
// Two-stage x/y/valid pipe that meets the one-cycle-late ROM colour at stage 2.
// Latency 2 cycles; no backpressure, i_flush kills both valid bits.
module plot_align_pipe
  import screen_pkg::*;
#(
  parameter int C_W = screen_pkg::COLOUR_W
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_flush,
  input  logic           i_vld,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  input  logic [C_W-1:0] i_c,
  output logic           o_vld,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [C_W-1:0] o_c
);
  logic [X_W-1:0] r_x_d1;
  logic [Y_W-1:0] r_y_d1;
  logic           r_v_d1;
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [C_W-1:0] r_c;
  logic           r_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x_d1 <= '0;
      r_y_d1 <= '0;
      r_v_d1 <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
      r_c    <= '0;
      r_v    <= 1'b0;
    end else begin
      r_x_d1 <= i_x;
      r_y_d1 <= i_y;
      r_v_d1 <= i_vld & ~i_flush;
      r_x    <= r_x_d1;
      r_y    <= r_y_d1;
      r_c    <= i_c;
      r_v    <= r_v_d1 & ~i_flush;
    end
  end

  assign o_vld = r_v;
  assign o_x   = r_x;
  assign o_y   = r_y;
  assign o_c   = r_c;
endmodule

// File: rtl/screen_plot_stage.sv
// Drawer-to-VGA stage: one plot per distinct coordinate, frame_done after WIDTH*HEIGHT plots.
// Latency 2 cycles, no backpressure; SCREEN_PLOT_CLIP_EN drops off-screen coordinates.
module screen_plot_stage
  import screen_pkg::*;
#(
  parameter int WIDTH    = screen_pkg::SCREEN_W,
  parameter int HEIGHT   = screen_pkg::SCREEN_H,
  parameter int COLOUR_W = screen_pkg::COLOUR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                draw_active,
  input  logic [7:0]          x_in,
  input  logic [6:0]          y_in,
  input  logic [COLOUR_W-1:0] c_in,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                frame_done,
  output logic                busy
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH * HEIGHT - 1);

  screen_state_t    r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first;
  logic [7:0]       r_last_x;
  logic [6:0]       r_last_y;
  logic             r_frame_done;

  logic w_stream;
  logic w_on;
  logic w_new;
  logic w_hit;
  logic w_flush;

`ifdef SCREEN_PLOT_CLIP_EN
  localparam logic [7:0] X_LIM = 8'(WIDTH);
  localparam logic [6:0] Y_LIM = 7'(HEIGHT);
  assign w_on = (x_in < X_LIM) && (y_in < Y_LIM);
`else
  assign w_on = 1'b1;
`endif

  assign w_stream = (r_state == STREAM);
  assign w_new    = w_stream && w_on && (r_first || ({x_in, y_in} != {r_last_x, r_last_y}));
  assign w_hit    = w_stream && vga_plot && (r_cnt == LAST_CNT);
  // Anything still in flight on abort, on the final plot, or outside STREAM is dropped.
  assign w_flush  = !(w_stream && draw_active && !w_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_first      <= 1'b1;
      r_last_x     <= '0;
      r_last_y     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (draw_active) begin
            r_state <= STREAM;
            r_cnt   <= '0;
            r_first <= 1'b1;
          end
        end
        STREAM: begin
          if (!draw_active) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            if (w_new) begin
              r_last_x <= x_in;
              r_last_y <= y_in;
              r_first  <= 1'b0;
            end
            if (vga_plot) begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cnt == LAST_CNT) begin
                r_state      <= DONE;
                r_frame_done <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          if (!draw_active) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  plot_align_pipe #(.C_W(COLOUR_W)) u_pipe (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_flush(w_flush),
    .i_vld  (w_new),
    .i_x    (x_in),
    .i_y    (y_in),
    .i_c    (c_in),
    .o_vld  (vga_plot),
    .o_x    (vga_x),
    .o_y    (vga_y),
    .o_c    (vga_colour)
  );

  assign frame_done = r_frame_done;
  assign busy       = w_stream;
endmodule

// File: tb/tb_screen_plot_stage.sv
// Directed bench: raster drawer model plus ROM, scoreboard of expected plots checked at negedge.
module tb_screen_plot_stage;
  import screen_pkg::*;
  localparam int PIX = SCREEN_PIXELS;

  logic       clk = 1'b0;
  logic       reset;
  logic       draw_active;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] c_in = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       frame_done;
  logic       busy;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int n_plot = 0;
  int n_fd = 0;
  int last_plot_t = 0;
  int pushed = 0;

  screen_plot_stage dut (
    .clk       (clk),
    .reset     (reset),
    .draw_active(draw_active),
    .x_in      (x_in),
    .y_in      (y_in),
    .c_in      (c_in),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .frame_done(frame_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // ROM model: colour for the address seen this cycle appears next cycle.
  always @(posedge clk) c_in <= 3'(int'(x_in) + int'(y_in));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (vga_plot === 1'b1) begin
        n_plot++;
        last_plot_t = cyc;
        chk("plot_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("plot_x", vga_x, e.x);
          chk("plot_y", vga_y, e.y);
          chk("plot_colour", vga_colour, e.c);
          chk("plot_latency", cyc, e.t + 2);
        end
      end
      if (frame_done === 1'b1) begin
        n_fd++;
        chk("fd_cycle_after_last_plot", cyc, last_plot_t + 1);
        chk("fd_plot_count", n_plot, PIX);
      end
    end
  endtask

  task automatic present(input int x, input int y, input int hold);
    bit on;
    x_in = 8'(x);
    y_in = 7'(y);
`ifdef SCREEN_PLOT_CLIP_EN
    on = (x < SCREEN_W) && (y < SCREEN_H);
`else
    on = 1'b1;
`endif
    if (on && pushed < PIX) begin
      q.push_back('{x, y, (x + y) % 8, cyc});
      pushed++;
    end
    repeat (hold) tick();
  endtask

  task automatic raster(input int hold, input int stop_at, input bit inject);
    int i = 0;
    for (int y = 0; y < SCREEN_H; y++) begin
      for (int x = 0; x < SCREEN_W; x++) begin
        if (i == stop_at) return;
        if (inject && i == 100) begin
          present(160, 0, 1);
          present(0, 120, 1);
        end
        present(x, y, (x == 5 && y == 3) ? 10 : hold);
        i++;
      end
    end
  endtask

  task automatic frame_start();
    n_plot = 0;
    n_fd = 0;
    pushed = 0;
    draw_active = 1'b1;
    tick();
    chk("busy_in_stream", busy, 1);
  endtask

  task automatic frame_end(input string tag);
    repeat (4) tick();
    chk({tag, "_fd_count"}, n_fd, 1);
    chk({tag, "_plots"}, n_plot, PIX);
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    reset = 1'b1;
    draw_active = 1'b0;
    x_in = '0;
    y_in = '0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_colour", vga_colour, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("idle_busy", busy, 0);

    // Full frame, 2-cycle hold, (5,3) held 10 cycles; then hold draw_active in DONE.
    frame_start();
    raster(2, -1, 1'b0);
    frame_end("frame1");
    repeat (100) tick();
    chk("done_hold_plots", n_plot, PIX);
    chk("done_hold_fd", n_fd, 1);
    chk("done_hold_busy", busy, 0);
    draw_active = 1'b0;
    tick();
    tick();

    // Abort after 1000 plots.
    frame_start();
    raster(1, 1000, 1'b0);
    repeat (3) tick();
    chk("abort_plots", n_plot, 1000);
    draw_active = 1'b0;
    repeat (3) tick();
    chk("abort_no_fd", n_fd, 0);
    chk("abort_busy", busy, 0);
    chk("abort_queue", q.size(), 0);

    frame_start();
    raster(1, -1, 1'b0);
    frame_end("frame2");
    draw_active = 1'b0;
    tick();
    tick();

    // Asynchronous reset mid-frame.
    frame_start();
    raster(1, 500, 1'b0);
    chk("plot_before_reset", vga_plot, 1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_plot", vga_plot, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_fd", frame_done, 0);
    q.delete();
    draw_active = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);

    // Off-screen injections; counter must restart from 0 after the reset.
    frame_start();
    raster(1, -1, 1'b1);
    frame_end("frame3");
    repeat (100) tick();
    chk("f3_hold_plots", n_plot, PIX);
    chk("f3_hold_fd", n_fd, 1);
    draw_active = 1'b0;
    tick();
    tick();
    draw_active = 1'b1;
    tick();
    chk("restart_from_idle", busy, 1);
    draw_active = 1'b0;
    tick();
    tick();
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
